// File: rtl/simon_pkg.sv
// Shared constants and state encoding for the Simon 128/128 bus adapter.
package simon_pkg;

    localparam int WORD_W    = 32;
    localparam int KEY_WORDS = 4;
    localparam int PT_WORDS  = 4;
    localparam int CT_WORDS  = 4;
    localparam int BLOCK_W   = WORD_W * CT_WORDS;
    localparam int BEAT_W    = $clog2(CT_WORDS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CT_WORDS - 1);

    // Adapter FSM state: LOAD -> START -> WAIT -> DRAIN -> LOAD
    typedef logic [1:0] state_t;
    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/simon_word_ser.sv
// Ciphertext serializer: holds a 128-bit block and presents it MSW-first,
// one 32-bit word per accepted beat, flagging the final beat.
module simon_word_ser
    import simon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,    // capture ct_i, restart beat count
    input  logic [BLOCK_W-1:0] ct_i,
    input  logic               active_i,  // outbound word is being offered
    input  logic               ready_i,   // sink accepts the offered word
    output logic [WORD_W-1:0]  data_o,
    output logic               last_o,
    output logic               done_o     // final beat transfers this cycle
);

    logic [BLOCK_W-1:0] sr_q, sr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;

    // Load a fresh block, or shift one word out per transfer
    always_comb begin
        sr_d   = sr_q;
        beat_d = beat_q;
        if (load_i) begin
            sr_d   = ct_i;
            beat_d = '0;
        end else if (active_i && ready_i) begin
            sr_d   = {sr_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    // Serializer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            beat_q <= '0;
        end else begin
            sr_q   <= sr_d;
            beat_q <= beat_d;
        end
    end

    assign data_o = sr_q[BLOCK_W-1:BLOCK_W-WORD_W];
    assign last_o = active_i && (beat_q == LAST_BEAT);
    assign done_o = active_i && ready_i && (beat_q == LAST_BEAT);

endmodule

// File: rtl/simon_bus_adapter.sv
// Word-stream adapter around a Simon 128/128 core: gathers 4 key words and
// 4 plaintext words, starts the core, waits for a fresh done edge and
// streams the 4 ciphertext words out.
//
// Handshakes: a word moves on a rising clk edge when its valid and ready are
// both high; valid is held with stable data until ready is seen, and ready
// never depends combinationally on valid.
module simon_bus_adapter
    import simon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [WORD_W-1:0]  m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_last_o,
    output logic               core_start_o,
    output logic [BLOCK_W-1:0] core_k0_o,
    output logic [BLOCK_W-1:0] core_pt_o,
    input  logic               core_valid_i,
    input  logic [BLOCK_W-1:0] core_ct_i,
    output logic               busy_o,
    output state_t             state_dbg_o
);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [BLOCK_W-1:0] k0_q, k0_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic               cv_q;
    logic               ser_load;
    logic               ser_done;

    // Next-state, word placement and completion-edge detection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k0_d     = k0_q;
        pt_d     = pt_q;
        ser_load = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_valid_i) begin
                    case (cnt_q)
                        3'd0: k0_d[127:96] = s_data_i;
                        3'd1: k0_d[95:64]  = s_data_i;
                        3'd2: k0_d[63:32]  = s_data_i;
                        3'd3: k0_d[31:0]   = s_data_i;
                        3'd4: pt_d[127:96] = s_data_i;
                        3'd5: pt_d[95:64]  = s_data_i;
                        3'd6: pt_d[63:32]  = s_data_i;
                        default: pt_d[31:0] = s_data_i;
                    endcase
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Only a fresh 0->1 transition counts; a done flag left high
                // from the previous block must not be taken as completion.
                if (core_valid_i && !cv_q) begin
                    ser_load = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ser_done) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Adapter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= 3'd0;
            k0_q    <= '0;
            pt_q    <= '0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k0_q    <= k0_d;
            pt_q    <= pt_d;
            cv_q    <= core_valid_i;
        end
    end

    simon_word_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ser_load),
        .ct_i     (core_ct_i),
        .active_i (m_valid_o),
        .ready_i  (m_ready_i),
        .data_o   (m_data_o),
        .last_o   (m_last_o),
        .done_o   (ser_done)
    );

    assign s_ready_o    = (state_q == ST_LOAD);
    assign busy_o       = (state_q != ST_LOAD);
    assign core_start_o = (state_q == ST_START);
    assign m_valid_o    = (state_q == ST_DRAIN);
    assign core_k0_o    = k0_q;
    assign core_pt_o    = pt_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_simon_bus_adapter.sv
// Bench for simon_bus_adapter: behavioural Simon 128/128 core, randomized
// load/sink driving, and a transaction-level model checked every cycle.
module tb_simon_bus_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_data_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [31:0]  m_data_o;
    logic         m_valid_o;
    logic         m_ready_i;
    logic         m_last_o;
    logic         core_start_o;
    logic [127:0] core_k0_o;
    logic [127:0] core_pt_o;
    logic         core_valid_i;
    logic [127:0] core_ct_i;
    logic         busy_o;
    logic [1:0]   state_dbg_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] KAT_PT  = 128'h63736564_20737265_6c6c6576_61727420;
    localparam logic [127:0] KAT_CT  = 128'h49681b1e_1e54fe3f_65aa832a_f84e0bbc;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    simon_bus_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o),
        .core_start_o (core_start_o),
        .core_k0_o    (core_k0_o),
        .core_pt_o    (core_pt_o),
        .core_valid_i (core_valid_i),
        .core_ct_i    (core_ct_i),
        .busy_o       (busy_o),
        .state_dbg_o  (state_dbg_o)
    );

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired) t=%0t", name, $time);
    endtask

    // ---------------- Simon 128/128 reference ----------------
    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [127:0] simon_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [63:0] k [0:67];
        logic [63:0] z;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] t;
        z    = 64'h3369F885192C0EF5;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            t = rol(k[i+1], 61);
            t = t ^ rol(t, 63);
            k[i+2] = ~k[i] ^ t ^ {63'd0, z[i % 62]} ^ 64'd3;
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // ---------------- behavioural core ----------------
    // Level done flag: after a start it keeps its old level for a few cycles,
    // drops, then rises with the new ciphertext after a random latency.
    logic [127:0] core_pend;
    int core_hold = 0;
    int core_lat  = 0;
    initial begin
        core_valid_i = 1'b0;
        core_ct_i    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_start_o) begin
                core_pend = simon_enc(core_k0_o, core_pt_o);
                core_hold = $urandom_range(1, 4);
                core_lat  = $urandom_range(2, 12);
            end else if (core_hold > 0) begin
                core_hold--;
                if (core_hold == 0) begin
                    core_valid_i = 1'b0;
                    core_ct_i    = {$urandom, $urandom, $urandom, $urandom};
                end
            end else if (core_lat > 0) begin
                core_lat--;
                if (core_lat == 0) begin
                    core_valid_i = 1'b1;
                    core_ct_i    = core_pend;
                end
            end
        end
    end

    // ---------------- sink driver ----------------
    int sink_mode = 0;  // 0 always ready, 1 random, 2 five-cycle stall per beat
    int stall = 0;
    initial begin
        m_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0: m_ready_i = 1'b1;
                1: m_ready_i = ($urandom_range(0, 1) == 1);
                default: begin
                    if (m_valid_o && stall < 5) begin
                        m_ready_i = 1'b0;
                        stall++;
                    end else begin
                        m_ready_i = m_valid_o;
                        if (m_valid_o) stall = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- transaction model + scoreboard ----------------
    // ph: 0 collecting words, 1 start due, 2 awaiting fresh core done, 3 draining
    int           ph = 0;
    logic [31:0]  acc_q[$];
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic [127:0] exp_key = '0;
    logic [127:0] exp_pt  = '0;
    logic [127:0] m_ct;
    logic         prev_cv = 1'b0;
    int           beat_cnt   = 0;
    int           dut_starts = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", 128'(m_valid_o), 128'(0));
            chk("rst_m_last", 128'(m_last_o), 128'(0));
            chk("rst_core_start", 128'(core_start_o), 128'(0));
            chk("rst_busy", 128'(busy_o), 128'(0));
            chk("rst_m_data", 128'(m_data_o), 128'(0));
            chk("rst_core_k0", core_k0_o, 128'(0));
            chk("rst_core_pt", core_pt_o, 128'(0));
            ph = 0;
            acc_q.delete();
            exp_q.delete();
        end else begin
            if (core_start_o) dut_starts++;
            chk("s_ready", 128'(s_ready_o), 128'(ph == 0));
            chk("busy", 128'(busy_o), 128'(ph != 0));
            chk("core_start", 128'(core_start_o), 128'(ph == 1));
            chk("m_valid", 128'(m_valid_o), 128'(ph == 3));
            if (ph != 0) begin
                chk("core_k0", core_k0_o, exp_key);
                chk("core_pt", core_pt_o, exp_pt);
            end
            case (ph)
                0: begin
                    if (s_valid_i) begin
                        acc_q.push_back(s_data_i);
                        if (acc_q.size() == 8) begin
                            exp_key = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
                            exp_pt  = {acc_q[4], acc_q[5], acc_q[6], acc_q[7]};
                            acc_q.delete();
                            ph = 1;
                        end
                    end
                end
                1: ph = 2;
                2: begin
                    if (core_valid_i && !prev_cv) begin
                        m_ct = simon_enc(exp_key, exp_pt);
                        for (int w = 0; w < 4; w++) begin
                            exp_q.push_back(m_ct[127:96]);
                            m_ct = m_ct << 32;
                        end
                        ph = 3;
                    end
                end
                default: begin
                    chk("m_data", 128'(m_data_o), 128'(exp_q[0]));
                    chk("m_last", 128'(m_last_o), 128'(exp_q.size() == 1));
                    if (m_ready_i) begin
                        got_q.push_back(m_data_o);
                        void'(exp_q.pop_front());
                        beat_cnt++;
                        if (exp_q.size() == 0) ph = 0;
                    end
                end
            endcase
        end
        prev_cv = core_valid_i;
    end

    // ---------------- stimulus tasks ----------------
    int ops_sent = 0;

    // Called and returns at posedge+1.
    task automatic send_op(input logic [127:0] key, input logic [127:0] pt,
                           input bit gaps, input bit hold_busy);
        logic [31:0] w [8];
        int idx = 0;
        int budget = 0;
        bit acc;
        for (int i = 0; i < 4; i++) begin
            w[i]     = key[127 - 32*i -: 32];
            w[i + 4] = pt[127 - 32*i -: 32];
        end
        while (idx < 8 && budget < 3000) begin
            s_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data_i  = s_valid_i ? w[idx] : $urandom;
            @(negedge clk);
            acc = s_valid_i && s_ready_o;
            @(posedge clk);
            #1;
            if (acc) idx++;
            budget++;
        end
        if (idx < 8) fail_now("send_op_timeout");
        else ops_sent++;
        if (hold_busy) begin
            int b = 0;
            s_valid_i = 1'b1;
            while (busy_o && b < 3000) begin
                s_data_i = $urandom;
                @(posedge clk);
                #1;
                b++;
            end
            if (b >= 3000) fail_now("hold_busy_timeout");
        end
        s_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while ((ph != 0 || busy_o) && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b >= 3000) fail_now(name);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, 128'(s_ready_o), 128'(1));
        chk({tag, "_busy"}, 128'(busy_o), 128'(0));
        chk({tag, "_m_valid"}, 128'(m_valid_o), 128'(0));
        chk({tag, "_m_data"}, 128'(m_data_o), 128'(0));
        chk({tag, "_core_k0"}, core_k0_o, 128'(0));
        chk({tag, "_core_pt"}, core_pt_o, 128'(0));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main sequence ----------------
    int exp_beats = 0;
    int base;
    int b;

    initial begin
        rst_n     = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
        @(posedge clk);
        #1;

        // Reference model pinned to the published test vector
        chk("model_kat", simon_enc(KAT_KEY, KAT_PT), KAT_CT);

        // Known-answer block, gap-free, sink always ready
        sink_mode = 0;
        send_op(KAT_KEY, KAT_PT, 1'b0, 1'b0);
        exp_beats += 4;
        wait_idle("kat_idle");
        if (got_q.size() >= 4) begin
            chk("kat_w0", 128'(got_q[0]), 128'(32'h49681b1e));
            chk("kat_w1", 128'(got_q[1]), 128'(32'h1e54fe3f));
            chk("kat_w2", 128'(got_q[2]), 128'(32'h65aa832a));
            chk("kat_w3", 128'(got_q[3]), 128'(32'hf84e0bbc));
        end else begin
            fail_now("kat_beats_missing");
        end

        // Same block loaded with random valid gaps, random sink
        sink_mode = 1;
        send_op(KAT_KEY, KAT_PT, 1'b1, 1'b0);
        exp_beats += 4;
        wait_idle("gap_kat_idle");
        chk("gap_kat_w3", 128'(got_q[got_q.size()-1]), 128'(32'hf84e0bbc));

        // Random blocks, random gaps, back-to-back (done still high)
        for (int i = 0; i < 4; i++) begin
            send_op(rnd128(), rnd128(), 1'b1, 1'b0);
            exp_beats += 4;
        end
        wait_idle("rand_idle");

        // Five-cycle stall on every beat
        sink_mode = 2;
        for (int i = 0; i < 2; i++) begin
            send_op(rnd128(), rnd128(), 1'b0, 1'b0);
            exp_beats += 4;
        end
        wait_idle("stall_idle");

        // s_valid held high through WAIT/DRAIN with junk data
        sink_mode = 1;
        send_op(rnd128(), rnd128(), 1'b1, 1'b1);
        exp_beats += 4;
        wait_idle("hold_idle");

        // Reset during WAIT
        sink_mode = 0;
        send_op(rnd128(), rnd128(), 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_wait");
        repeat (25) @(posedge clk);
        #1;

        // Reset during DRAIN after two beats
        base = beat_cnt;
        send_op(rnd128(), rnd128(), 1'b0, 1'b0);
        exp_beats += 2;
        b = 0;
        while (beat_cnt < base + 2 && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b >= 3000) fail_now("drain_beat2_timeout");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_drain");
        repeat (25) @(posedge clk);
        #1;

        // Recovery after reset
        sink_mode = 1;
        send_op(KAT_KEY, KAT_PT, 1'b1, 1'b0);
        exp_beats += 4;
        wait_idle("recover_idle");
        chk("recover_w0", 128'(got_q[got_q.size()-4]), 128'(32'h49681b1e));

        chk("total_beats", 128'(beat_cnt), 128'(exp_beats));
        chk("start_pulses", 128'(dut_starts), 128'(ops_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_bus_adapter.md
SIMON_BUS_ADAPTER -- requirements
Module: simon_bus_adapter

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-003 SHALL have port s_data_i, input, 32 bits, inbound word (key words first, then plaintext words).
REQ-004 SHALL have port s_valid_i, input, 1 bit, inbound word present.
REQ-005 SHALL have port s_ready_o, output, 1 bit, adapter accepts an inbound word.
REQ-006 SHALL have port m_data_o, output, 32 bits, outbound ciphertext word.
REQ-007 SHALL have port m_valid_o, output, 1 bit, outbound word present.
REQ-008 SHALL have port m_ready_i, input, 1 bit, sink accepts the outbound word.
REQ-009 SHALL have port m_last_o, output, 1 bit, marks the 4th (final) ciphertext word.
REQ-010 SHALL have port core_start_o, output, 1 bit, start pulse to the Simon 128/128 core.
REQ-011 SHALL have ports core_k0_o and core_pt_o, outputs, 128 bits each, key and plaintext to the core.
REQ-012 SHALL have port core_valid_i, input, 1 bit, level-type core done flag.
REQ-013 SHALL have port core_ct_i, input, 128 bits, core ciphertext.
REQ-014 SHALL have port busy_o, output, 1 bit, high in every state except LOAD.

Function
REQ-015 SHALL implement the FSM LOAD -> START -> WAIT -> DRAIN -> LOAD.
REQ-016 SHALL assert s_ready_o only in LOAD, with a word transferring when s_valid_i and s_ready_o are both high on a clock edge.
REQ-017 SHALL use a 3-bit word counter: words 0-3 fill core_k0_o[127:96], [95:64], [63:32], [31:0] in order, and words 4-7 fill core_pt_o in the same MSW-first order.
REQ-018 SHALL, when word 7 is accepted, reset the counter to 0 and go to START.
REQ-019 SHALL hold core_start_o high for exactly the one cycle spent in START, then go to WAIT.
REQ-020 SHALL keep core_k0_o and core_pt_o stable from START until the next LOAD transfer.
REQ-021 SHALL register core_valid_i each cycle, and in WAIT SHALL detect a rising edge only: current value high, registered value low. A core_valid_i left high from a previous operation SHALL NOT count as completion.
REQ-022 SHALL, on that rising edge, capture core_ct_i into a 128-bit shift register and go to DRAIN.
REQ-023 SHALL, in DRAIN, present ciphertext MSW-first, with m_valid_o high from the first DRAIN cycle.
REQ-024 SHALL hold m_data_o and m_last_o stable while m_valid_o && !m_ready_i (backpressure).
REQ-025 SHALL shift on each m_valid_o && m_ready_i transfer, with m_last_o high on the 4th word only.
REQ-026 SHALL, on the 4th transfer, drop m_valid_o in the next cycle and return to LOAD.
REQ-027 SHALL ignore s_valid_i and s_data_i outside LOAD, since s_ready_o is low there.
REQ-028 SHALL allow no overlap: a new load begins only after DRAIN completes.
REQ-029 SHALL give a load-to-first-output latency of 1 (START) + core latency + 1 cycle.

Reset
REQ-030 SHALL, while rst_n is low, force: state LOAD; counter 0; s_ready_o 1 after reset release; m_valid_o, m_last_o, core_start_o, busy_o 0; m_data_o, core_k0_o, core_pt_o, shift register all 0; registered core_valid 0.
REQ-031 SHALL, on reset mid-operation in any state, abandon all partial words and pending ciphertext and emit no outbound word afterwards.

Structure
REQ-032 SHALL place the state typedef (LOAD/START/WAIT/DRAIN) and constants WORD_W=32, KEY_WORDS=4, PT_WORDS=4, CT_WORDS=4 in shared package simon_pkg.
REQ-033 SHALL place the output serializer (shift register, beat counter, m_last_o generation) in sub-module simon_word_ser; all other logic stays in the adapter.

Verification
REQ-034 SHALL cover this scenario: stream key words 0f0e0d0c, 0b0a0908, 07060504, 03020100, then pt words 63736564, 20737265, 6c6c6576, 61727420, with the core connected -> out words 49681b1e, 1e54fe3f, 65aa832a, f84e0bbc, m_last_o on the 4th.
REQ-035 SHALL cover this scenario: s_valid_i toggled randomly during load -> captured core_k0_o/core_pt_o are identical to gap-free loading, and exactly one core_start_o pulse occurs.
REQ-036 SHALL cover this scenario: m_ready_i low for 5 cycles on each beat -> m_data_o stable during stalls, no beat lost or duplicated.
REQ-037 SHALL cover this scenario: second encryption back-to-back with core_valid_i still high from the first -> no early capture, and the output matches the second vector.
REQ-038 SHALL cover this scenario: rst_n pulsed low during WAIT and during DRAIN after beat 2 -> all outputs at reset values, s_ready_o 1, no further m_valid_o until a new load.
REQ-039 SHALL cover this scenario: s_valid_i held high during WAIT/DRAIN -> s_ready_o stays 0 and no word is absorbed.
